// File: rtl/uart_tx_word_sequencer.sv
// uart_tx_word_sequencer
// Queues CPU words in a small FIFO and feeds them, one UART_Nbit byte at a
// time and LSB first, to a byte-level UART transmitter. The handshake is
// Transmit (start) -> endTx_flag (done) -> clr_tx_flag (acknowledge).
// Optional build macro: UART_SEQ_NEWLINE_EN appends a 0x0A byte after each word.
module uart_tx_word_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int UART_Nbit  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] uart_tx,
  input  logic                  Start_Tx,
  output logic [DATA_WIDTH-1:0] Tx_status_out,
  output logic [UART_Nbit-1:0]  DataTx,
  output logic                  Transmit,
  input  logic                  endTx_flag,
  output logic                  clr_tx_flag
);

  localparam int PTR_W          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W          = PTR_W + 1;
  localparam int BYTES_PER_WORD = DATA_WIDTH / UART_Nbit;

  localparam logic [2:0]       LAST_BYTE = 3'(BYTES_PER_WORD - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef UART_SEQ_NEWLINE_EN
  localparam logic [DATA_WIDTH-1:0] NEWLINE_CHAR = DATA_WIDTH'(8'h0A);

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND, WAIT_END, CLEAR, SHIFT, NEWLINE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, LOAD, SEND, WAIT_END, CLEAR, SHIFT
  } state_t;
`endif

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  overflow_reg;

  // Sequencer state
  state_t                state_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [2:0]            byte_cnt_reg;

  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push;
  logic drop;
  logic busy;

  assign fifo_full  = (count_reg == DEPTH_CNT);
  assign fifo_empty = (count_reg == '0);

  // The head is consumed on the LOAD cycle; a full FIFO can still accept a
  // word on that same edge because a slot frees up simultaneously.
  assign pop  = (state_reg == LOAD);
  assign push = Start_Tx && (!fifo_full || pop);
  assign drop = Start_Tx && fifo_full && !pop;

  assign busy = (state_reg != IDLE) || !fifo_empty;

  assign Tx_status_out = {{(DATA_WIDTH-3){1'b0}}, overflow_reg, fifo_full, busy};

  // FIFO data array: written on accepted pushes, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= uart_tx;
    end
  end

  // FIFO pointers, occupancy count and sticky overflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Byte sequencer: pulses Transmit / clr_tx_flag as registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      byte_cnt_reg <= '0;
      DataTx       <= '0;
      Transmit     <= 1'b0;
      clr_tx_flag  <= 1'b0;
    end else begin
      Transmit    <= 1'b0;
      clr_tx_flag <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          shift_reg    <= fifo_mem[rd_ptr_reg];
          byte_cnt_reg <= '0;
          state_reg    <= SEND;
        end
        SEND: begin
          DataTx    <= shift_reg[UART_Nbit-1:0];
          Transmit  <= 1'b1;
          state_reg <= WAIT_END;
        end
        WAIT_END: begin
          // DataTx is left untouched so the transmitter sees a stable byte
          if (endTx_flag) begin
            clr_tx_flag <= 1'b1;
            state_reg   <= CLEAR;
          end
        end
        CLEAR: begin
          if (byte_cnt_reg < LAST_BYTE) begin
            state_reg <= SHIFT;
          end
`ifdef UART_SEQ_NEWLINE_EN
          else if (byte_cnt_reg == LAST_BYTE) begin
            state_reg <= NEWLINE;
          end
`endif
          else if (!fifo_empty) begin
            state_reg <= LOAD;
          end else begin
            state_reg <= IDLE;
          end
        end
        SHIFT: begin
          shift_reg    <= shift_reg >> UART_Nbit;
          byte_cnt_reg <= byte_cnt_reg + 3'd1;
          state_reg    <= SEND;
        end
`ifdef UART_SEQ_NEWLINE_EN
        NEWLINE: begin
          // byte_cnt moves past the last data byte so CLEAR ends the word
          shift_reg    <= NEWLINE_CHAR;
          byte_cnt_reg <= byte_cnt_reg + 3'd1;
          state_reg    <= SEND;
        end
`endif
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
